// File: rtl/jt1943_objbus_pkg.sv
// Shared types and defaults for the object-RAM bus arbiter.
package jt1943_objbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [12:0] OKOUT_ADDR_DEF = 13'h1804;
  localparam logic [7:0]  WAIT_MAX_DEF   = 8'd200;

endpackage

// File: rtl/jtgng_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module jtgng_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/jt1943_objbus_arb.sv
// Object-RAM bus arbiter: halts the Z80 via BUSRQ/BUSAK, grants the RAM port to the
// sprite DMA, generates the OKOUT start pulse and returns RAM data to the DMA on DB.
module jt1943_objbus_arb
  import jt1943_objbus_pkg::*;
#(
  parameter logic [12:0] OKOUT_ADDR = OKOUT_ADDR_DEF,
  parameter logic [7:0]  WAIT_MAX   = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic [12:0] cpu_AB,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wrn,
  input  logic        cpu_obj_cs,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  output logic        OKOUT,
  input  logic        bus_req,
  output logic        bus_ack,
  input  logic        blen,
  input  logic [12:0] obj_AB,
  output logic [7:0]  DB,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        stall
);

  state_t      state_q, state_d;
  logic        busrq_n_q, busrq_n_d;
  logic        bus_ack_q, bus_ack_d;
  logic        stall_q, stall_d;
  logic [7:0]  wait_q, wait_d;
  logic        busak_s;
  logic        wrn_q, pend_q, okout_q, ok_hit;
  logic        okout_wr;
  logic [7:0]  db_q;

  jtgng_sync2 #(.RST_VAL(1'b1)) u_busak_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cpu_busak_n),
    .q_o (busak_s)
  );

  always_comb begin
    state_d   = state_q;
    busrq_n_d = busrq_n_q;
    bus_ack_d = bus_ack_q;
    stall_d   = stall_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: begin
        if (bus_req) begin
          state_d   = REQ;
          busrq_n_d = 1'b0;
          wait_d    = '0;
        end
      end
      REQ: begin
        // A withdrawn request wins over a late BUSAK so the DMA never sees an ack.
        if (!bus_req) begin
          state_d   = RELEASE;
          busrq_n_d = 1'b1;
        end else if (!busak_s) begin
          state_d   = GRANT;
          bus_ack_d = 1'b1;
        end else begin
          if (wait_q != '1) wait_d = wait_q + 8'd1;
          if (wait_d >= WAIT_MAX) stall_d = 1'b1;
        end
      end
      GRANT: begin
        if (!bus_req) begin
          state_d   = RELEASE;
          bus_ack_d = 1'b0;
          busrq_n_d = 1'b1;
        end
      end
      RELEASE: begin
        if (busak_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busrq_n_q <= 1'b1;
      bus_ack_q <= 1'b0;
      stall_q   <= 1'b0;
      wait_q    <= '0;
    end else if (cen6) begin
      state_q   <= state_d;
      busrq_n_q <= busrq_n_d;
      bus_ack_q <= bus_ack_d;
      stall_q   <= stall_d;
      wait_q    <= wait_d;
    end
  end

  // OKOUT request: falling edge of cpu_wrn on the trigger address, stretched to one cen6 period.
  assign okout_wr = cpu_obj_cs && (cpu_AB == OKOUT_ADDR);
  assign ok_hit   = okout_wr & wrn_q & ~cpu_wrn;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrn_q   <= 1'b1;
      pend_q  <= 1'b0;
      okout_q <= 1'b0;
    end else begin
      wrn_q <= cpu_wrn;
      if (cen6) begin
        okout_q <= pend_q | ok_hit;
        pend_q  <= 1'b0;
      end else if (ok_hit) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          db_q <= '0;
    else if (cen6 && bus_ack_q && blen) db_q <= ram_dout;
  end

  // The trigger address is a strobe register, not RAM, so its writes are kept out of memory.
  assign ram_addr    = bus_ack_q ? obj_AB : cpu_AB;
  assign ram_we      = ~bus_ack_q & cpu_obj_cs & ~cpu_wrn & ~okout_wr;
  assign ram_din     = cpu_dout;
  assign cpu_busrq_n = busrq_n_q;
  assign bus_ack     = bus_ack_q;
  assign stall       = stall_q;
  assign OKOUT       = okout_q;
  assign DB          = db_q;

endmodule

// File: tb/tb_jt1943_objbus_arb.sv
// Directed bench for jt1943_objbus_arb with a Z80 BUSAK model, a behavioural RAM and scoreboards.
module tb_jt1943_objbus_arb;

  localparam logic [12:0] OK_ADDR = 13'h1804;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen6 = 1'b0;
  logic [1:0]  cen_cnt = 2'd0;
  logic [12:0] cpu_AB = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wrn = 1'b1;
  logic        cpu_obj_cs = 1'b0;
  logic        cpu_busrq_n;
  logic        cpu_busak_n = 1'b1;
  logic        OKOUT;
  logic        bus_req = 1'b0;
  logic        bus_ack;
  logic        blen = 1'b0;
  logic [12:0] obj_AB = '0;
  logic [7:0]  DB;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        stall;

  logic        busak_en = 1'b1;
  logic [7:0]  mem [0:8191] = '{default: 8'h00};
  int          errors = 0;
  int          checks = 0;
  int          ok_rises = 0;
  int          ok_cycles = 0;
  logic        ok_prev = 1'b0;
  logic [7:0]  db_exp_q[$];
  int          ok_exp_q[$];

  jt1943_objbus_arb #(.OKOUT_ADDR(OK_ADDR), .WAIT_MAX(8'd200)) dut (
    .clk(clk), .rst(rst), .cen6(cen6),
    .cpu_AB(cpu_AB), .cpu_dout(cpu_dout), .cpu_wrn(cpu_wrn), .cpu_obj_cs(cpu_obj_cs),
    .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n), .OKOUT(OKOUT),
    .bus_req(bus_req), .bus_ack(bus_ack), .blen(blen), .obj_AB(obj_AB), .DB(DB),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // cen6 changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    cen_cnt <= cen_cnt + 2'd1;
    cen6    <= (cen_cnt == 2'd2);
  end

  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  // Z80 model: acknowledges on the third cen6 tick after BUSRQ is seen low.
  int ak_cnt = 0;
  always @(posedge clk) begin
    if (cen6) begin
      if (cpu_busrq_n) begin
        ak_cnt = 0;
        cpu_busak_n <= 1'b1;
      end else if (busak_en) begin
        if (ak_cnt == 2) cpu_busak_n <= 1'b0;
        else ak_cnt = ak_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (OKOUT) ok_cycles = ok_cycles + 1;
    if (OKOUT && !ok_prev) ok_rises = ok_rises + 1;
    ok_prev = OKOUT;
  end

  task automatic tick();
    forever begin
      @(posedge clk);
      if (cen6) break;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
    cpu_AB = a; cpu_dout = d; cpu_obj_cs = 1'b1; cpu_wrn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_wrn = 1'b1; cpu_obj_cs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic get_bus(input string tag);
    busak_en = 1'b1;
    bus_req  = 1'b1;
    tick();
    check({tag, "_busrq_lat"}, 16'(cpu_busrq_n), 16'd0);
    for (int i = 0; i < 10 && cpu_busak_n; i++) tick();
    check({tag, "_busak_seen"}, 16'(cpu_busak_n), 16'd0);
    for (int i = 0; i < 4 && !bus_ack; i++) tick();
    check({tag, "_bus_ack"}, 16'(bus_ack), 16'd1);
  endtask

  task automatic drop_bus(input string tag);
    bus_req = 1'b0;
    for (int i = 0; i < 10 && (bus_ack || !cpu_busak_n); i++) tick();
    repeat (3) tick();
    check({tag, "_ack_off"}, 16'(bus_ack), 16'd0);
    check({tag, "_busrq_off"}, 16'(cpu_busrq_n), 16'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_busrq_n", 16'(cpu_busrq_n), 16'd1);
    check("rst_bus_ack", 16'(bus_ack), 16'd0);
    check("rst_okout", 16'(OKOUT), 16'd0);
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_db", 16'(DB), 16'd0);
    check("rst_ram_we", 16'(ram_we), 16'd0);
    rst = 1'b0;
    tick();

    // 1: grant handshake and DMA address muxing
    get_bus("t1");
    obj_AB = 13'h0123; #1;
    check("t1_ram_addr", 16'(ram_addr), 16'h0123);

    // 2: CPU write dropped during grant, lands after release
    cpu_AB = 13'h0010; cpu_dout = 8'hA5; cpu_obj_cs = 1'b1; cpu_wrn = 1'b0;
    @(posedge clk); #1;
    check("t2_we_blocked", 16'(ram_we), 16'd0);
    @(posedge clk); #1;
    cpu_wrn = 1'b1; cpu_obj_cs = 1'b0;
    @(posedge clk); #1;
    check("t2_ram_kept", 16'(mem[16]), 16'h00);
    drop_bus("t2");
    cpu_write(13'h0010, 8'hA5);
    check("t2_ram_written", 16'(mem[16]), 16'hA5);

    // 3: two OKOUT writes inside one cen6 period merge into one pulse
    tick();
    r0 = ok_rises; c0 = ok_cycles;
    ok_exp_q.push_back(1);
    ok_exp_q.push_back(4);
    cpu_AB = OK_ADDR; cpu_obj_cs = 1'b1; cpu_wrn = 1'b0;
    @(posedge clk); #1; cpu_wrn = 1'b1;
    @(posedge clk); #1; cpu_wrn = 1'b0;
    @(posedge clk); #1; cpu_wrn = 1'b1; cpu_obj_cs = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t3_ok_pulses", 16'(ok_rises - r0), 16'(ok_exp_q.pop_front()));
    check("t3_ok_width", 16'(ok_cycles - c0), 16'(ok_exp_q.pop_front()));

    // 5: reset in GRANT with a loaded DB
    for (int i = 0; i < 4; i++) cpu_write(13'(i), 8'h10 + 8'(i));
    get_bus("t5");
    obj_AB = 13'h0000; blen = 1'b1;
    tick(); tick();
    blen = 1'b0;
    check("t5_db_loaded", 16'(DB), 16'h0010);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_ack_rst", 16'(bus_ack), 16'd0);
    check("t5_busrq_rst", 16'(cpu_busrq_n), 16'd1);
    check("t5_db_rst", 16'(DB), 16'd0);
    rst = 1'b0; bus_req = 1'b0;
    tick(); tick();
    bus_req = 1'b1;
    tick();
    check("t5_idle_rereq", 16'(cpu_busrq_n), 16'd0);
    bus_req = 1'b0;
    repeat (6) tick();

    // 6: DB streams RAM data one cen6 after each DMA address
    get_bus("t6");
    blen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obj_AB = 13'(i);
      db_exp_q.push_back(8'h10 + 8'(i));
      tick();
      check($sformatf("t6_db%0d", i), 16'(DB), 16'(db_exp_q.pop_front()));
    end
    blen = 1'b0;
    drop_bus("t6");

    // 4: BUSAK never answers
    busak_en = 1'b0;
    bus_req  = 1'b1;
    tick();
    check("t4_busrq_low", 16'(cpu_busrq_n), 16'd0);
    repeat (190) tick();
    check("t4_no_stall_yet", 16'(stall), 16'd0);
    repeat (15) tick();
    check("t4_stall", 16'(stall), 16'd1);
    check("t4_no_ack", 16'(bus_ack), 16'd0);
    bus_req = 1'b0;
    repeat (3) tick();
    check("t4_busrq_rel", 16'(cpu_busrq_n), 16'd1);
    bus_req = 1'b1;
    tick();
    check("t4_idle_rereq", 16'(cpu_busrq_n), 16'd0);
    check("t4_stall_sticky", 16'(stall), 16'd1);
    bus_req = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
